// File: rtl/sys_timer_pkg.sv
// Shared types for the system counter block: the CSR counter select encoding.
package SysTimerConsts;

  typedef enum logic [1:0] {
    CYCLE   = 2'd0,
    TIME    = 2'd1,
    INSTRET = 2'd2
  } Type;

endpackage

// File: rtl/sys_timer_if.sv
// Read path between the CSR execute unit and the system counters.
interface SysTimerIF;
  import SysTimerConsts::*;

  Type         timer;
  logic        upper;
  logic [31:0] data;

  modport SysTimerPort (
    input  timer,
    input  upper,
    output data
  );

  modport CSRUnitPort (
    output timer,
    output upper,
    input  data
  );

endinterface

// File: rtl/sys_counter64.sv
// 64-bit wrapping up-counter with a parameterised reset value.
module sys_counter64 #(
  parameter logic [63:0] INIT = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [63:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (inc) begin
      q <= q + 64'd1;
    end
  end

endmodule

// File: rtl/sys_timer.sv
// Cycle, time and instret counters for the RV32I user counter CSRs, with a
// zero-latency 32-bit read mux driven from registered state only.
module sys_timer
  import SysTimerConsts::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned TIME_FREQ_HZ = 1_000_000,
  parameter logic [63:0] CYCLE_INIT   = 64'h0,
  parameter logic [63:0] TIME_INIT    = 64'h0,
  parameter logic [63:0] INSTRET_INIT = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire,
  SysTimerIF.SysTimerPort       sys_timer_if
);

  localparam int unsigned TimeFreq = (TIME_FREQ_HZ == 0) ? 1 : TIME_FREQ_HZ;
  localparam int unsigned DIV      = CLK_FREQ_HZ / TimeFreq;

  if (TIME_FREQ_HZ == 0 || (CLK_FREQ_HZ % TimeFreq) != 0 || DIV < 1) begin : g_bad_freq
    $fatal(1, "sys_timer: CLK_FREQ_HZ must be a non-zero multiple of TIME_FREQ_HZ");
  end

  logic        time_tick;
  logic [63:0] cycle_q;
  logic [63:0] time_q;
  logic [63:0] instret_q;

  if (DIV == 1) begin : g_no_presc
    assign time_tick = 1'b1;
  end else begin : g_presc
    localparam int unsigned PW = $clog2(DIV);

    logic [PW-1:0] presc_q;

    assign time_tick = (presc_q == PW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        presc_q <= '0;
      end else if (time_tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  sys_counter64 #(
    .INIT (CYCLE_INIT)
  ) u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .q     (cycle_q)
  );

  sys_counter64 #(
    .INIT (TIME_INIT)
  ) u_time (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (time_tick),
    .q     (time_q)
  );

  sys_counter64 #(
    .INIT (INSTRET_INIT)
  ) u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .q     (instret_q)
  );

  // Reads see pre-increment state, so an instruction reading instret as it
  // retires observes the old count.
  logic [63:0] sel_val;

  always_comb begin
    sel_val = 64'h0;
    case (sys_timer_if.timer)
      CYCLE:   sel_val = cycle_q;
      TIME:    sel_val = time_q;
      INSTRET: sel_val = instret_q;
      default: sel_val = 64'h0;
    endcase
  end

  assign sys_timer_if.data = sys_timer_if.upper ? sel_val[63:32] : sel_val[31:0];

endmodule

// File: tb/tb_sys_timer.sv
// Directed plus randomized bench for sys_timer across four parameterisations.
module tb_sys_timer;
  import SysTimerConsts::*;

  logic clk;
  logic rst_n;
  logic retire;
  Type  sel_t;
  logic sel_u;

  int errors = 0;
  int checks = 0;

  // Edges since reset release, and retires accepted since reset release.
  logic [63:0] n = 64'd0;
  logic [63:0] r = 64'd0;

  SysTimerIF if_a ();
  SysTimerIF if_b ();
  SysTimerIF if_c ();
  SysTimerIF if_d ();

  assign if_a.timer = sel_t;
  assign if_a.upper = sel_u;
  assign if_b.timer = sel_t;
  assign if_b.upper = sel_u;
  assign if_c.timer = sel_t;
  assign if_c.upper = sel_u;
  assign if_d.timer = sel_t;
  assign if_d.upper = sel_u;

  logic [31:0] dat [4];
  assign dat[0] = if_a.data;
  assign dat[1] = if_b.data;
  assign dat[2] = if_c.data;
  assign dat[3] = if_d.data;

  // DIV = 50, TIME_INIT = 5
  sys_timer #(
    .CLK_FREQ_HZ  (50_000_000),
    .TIME_FREQ_HZ (1_000_000),
    .CYCLE_INIT   (64'h0),
    .TIME_INIT    (64'h5),
    .INSTRET_INIT (64'h0)
  ) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .sys_timer_if (if_a.SysTimerPort)
  );

  // DIV = 4
  sys_timer #(
    .CLK_FREQ_HZ  (4_000_000),
    .TIME_FREQ_HZ (1_000_000),
    .CYCLE_INIT   (64'h0),
    .TIME_INIT    (64'h0),
    .INSTRET_INIT (64'h0)
  ) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .sys_timer_if (if_b.SysTimerPort)
  );

  // DIV = 1
  sys_timer #(
    .CLK_FREQ_HZ  (1_000_000),
    .TIME_FREQ_HZ (1_000_000),
    .CYCLE_INIT   (64'h0),
    .TIME_INIT    (64'h0),
    .INSTRET_INIT (64'h0)
  ) u_dut_c (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .sys_timer_if (if_c.SysTimerPort)
  );

  // Carry and wrap boundaries
  sys_timer #(
    .CLK_FREQ_HZ  (50_000_000),
    .TIME_FREQ_HZ (1_000_000),
    .CYCLE_INIT   (64'h0000_0000_FFFF_FFFF),
    .TIME_INIT    (64'h0),
    .INSTRET_INIT (64'hFFFF_FFFF_FFFF_FFFF)
  ) u_dut_d (
    .clk          (clk),
    .rst_n        (rst_n),
    .retire       (retire),
    .sys_timer_if (if_d.SysTimerPort)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 64'd0;
      r <= 64'd0;
    end else begin
      n <= n + 64'd1;
      r <= r + (retire ? 64'd1 : 64'd0);
    end
  end

  // Counter value = init + elapsed events; time counts whole prescale periods.
  function automatic logic [31:0] model(input int k, input logic [1:0] t, input logic u);
    logic [63:0] v, div, ci, ti, ii;
    ci  = 64'h0;
    ti  = 64'h0;
    ii  = 64'h0;
    div = 64'd50;
    case (k)
      0:       ti = 64'h5;
      1:       div = 64'd4;
      2:       div = 64'd1;
      default: begin
        ci = 64'h0000_0000_FFFF_FFFF;
        ii = 64'hFFFF_FFFF_FFFF_FFFF;
      end
    endcase
    case (t)
      2'd0:    v = ci + n;
      2'd1:    v = ti + n / div;
      2'd2:    v = ii + r;
      default: v = 64'h0;
    endcase
    return u ? v[63:32] : v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_dut%0d_t%0d_u%0d", tag, k, sel_t, sel_u), dat[k],
          model(k, sel_t, sel_u));
    end
  endtask

  initial begin
    logic [4:0] pat;
    pat    = 5'b01011;
    rst_n  = 1'b0;
    retire = 1'b0;
    sel_t  = TIME;
    sel_u  = 1'b0;

    // Reset visibility
    repeat (2) @(negedge clk);
    #1;
    chk("rst_time_lo", dat[0], 32'd5);
    check_all("rst");

    // Release, one edge with a retire: 32-bit carry and 64-bit wrap
    @(negedge clk);
    rst_n  = 1'b1;
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    sel_t  = CYCLE;
    #1 chk("carry_lo", dat[3], 32'd0);
    sel_u = 1'b1;
    #1 chk("carry_hi", dat[3], 32'd1);
    sel_t = INSTRET;
    #1 chk("wrap_hi", dat[3], 32'd0);
    sel_u = 1'b0;
    #1 chk("wrap_lo", dat[3], 32'd0);

    // Ten edges total with DIV=50
    repeat (9) @(negedge clk);
    sel_t = TIME;
    #1 chk("div50_time", dat[0], 32'd5);
    sel_t = CYCLE;
    #1 chk("div50_cycle", dat[0], 32'd10);

    // Seventeen edges total with DIV=4
    repeat (7) @(negedge clk);
    sel_t = TIME;
    #1 chk("div4_time", dat[1], 32'd4);
    chk("div1_time", dat[2], 32'd17);
    sel_t = CYCLE;
    #1 chk("div4_cycle", dat[1], 32'd17);
    check_all("run17");

    // Async reset between edges; retire held during reset is lost
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    retire = 1'b1;
    #1 chk("async_cycle", dat[0], 32'd0);
    chk("async_carry_lo", dat[3], 32'hFFFF_FFFF);
    sel_t = TIME;
    #1 chk("async_time", dat[0], 32'd5);
    check_all("async");
    @(negedge clk);
    @(negedge clk);
    sel_t = INSTRET;
    #1 chk("retire_lost", dat[0], 32'd0);

    // Retire pattern 1,1,0,1,0 with a same-cycle read on the third retire
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      retire = pat[i];
      #1;
      if (i == 3) chk("own_retire", dat[0], 32'd2);
      @(negedge clk);
    end
    retire = 1'b0;
    #1 chk("instret_pat", dat[0], 32'd3);
    check_all("pat");

    // Unused select encoding reads zero
    sel_t = Type'(2'b11);
    for (int u = 0; u < 2; u++) begin
      sel_u = u[0];
      #1;
      for (int k = 0; k < 4; k++) chk($sformatf("badsel_dut%0d_u%0d", k, u), dat[k], 32'd0);
    end

    // Randomized traffic with one mid-run reset pulse
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst_n  = (i != 150);
      retire = 1'($urandom_range(0, 1));
      sel_t  = Type'($urandom_range(0, 3));
      sel_u  = 1'($urandom_range(0, 1));
      #1 check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
